pktunit_stream_joiner: RTL and testbench

Joins the three split per-port packet-unit streams (data, flags, eop) from the raw-socket testbed interface into a single AXI-Stream beat stream (tdata/tkeep/tlast/tuser) for DUTs with a native AXIS ingress. One instance per port, sitting between the testbed feeder outputs and the DUT. Provides a 2-entry output buffer, a packet-length guard with truncate-and-drop, and sticky protocol-error flags with counters.

---
 rtl/pktunit_stream_joiner.sv | 249 ++++++++++++++++++++++++
 tb/tb_pktunit_stream_joiner.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pktunit_stream_joiner.sv
// Merges the split data/flags/eop packet-unit streams of one port into a single AXI-Stream
// beat stream, with a 2-entry output buffer, a packet-length guard and sticky error reporting.
module pktunit_stream_joiner #(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned MAX_BEATS  = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_BYTES*8-1:0]   s_data_d,
  input  logic                      s_data_v,
  output logic                      s_data_r,
  input  logic [7:0]                s_flags_d,
  input  logic                      s_flags_v,
  output logic                      s_flags_r,
  input  logic [DATA_BYTES-1:0]     s_eop_d,
  input  logic                      s_eop_v,
  output logic                      s_eop_r,
  output logic [DATA_BYTES*8-1:0]   m_axis_tdata,
  output logic [DATA_BYTES-1:0]     m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [7:0]                m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      clr_err,
  output logic                      err_mask,
  output logic                      err_overlen,
  output logic [31:0]               pkt_cnt,
  output logic [15:0]               drop_cnt
);

  localparam int unsigned DW = DATA_BYTES * 8;
  localparam int unsigned KW = DATA_BYTES;
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_PKT,
    ST_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [7:0]      flags_q, flags_d;
  logic [1:0]      count_q, count_d;
  logic [DW-1:0]   out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [KW-1:0]   out_keep_q, out_keep_d, skid_keep_q, skid_keep_d;
  logic            out_last_q, out_last_d, skid_last_q, skid_last_d;
  logic [7:0]      out_user_q, out_user_d, skid_user_q, skid_user_d;
  logic            err_mask_q, err_mask_d;
  logic            err_overlen_q, err_overlen_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            space;
  logic            toks_v;
  logic            eop_last;
  logic            mask_bad;
  logic            fire;
  logic            consume;
  logic            set_mask;
  logic            set_overlen;
  logic [CW-1:0]   cnt_next;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [KW-1:0]   wr_keep;
  logic            wr_last;
  logic [7:0]      wr_user;
  logic            rd_en;

  // Packet FSM: token join, beat formatting, length guard and error detection
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    flags_d     = flags_q;
    drop_cnt_d  = drop_cnt_q;
    s_data_r    = 1'b0;
    s_eop_r     = 1'b0;
    s_flags_r   = 1'b0;
    fire        = 1'b0;
    consume     = 1'b0;
    set_mask    = 1'b0;
    set_overlen = 1'b0;
    space       = (count_q != 2'd2);
    toks_v      = s_data_v & s_eop_v;
    eop_last    = |s_eop_d;
    mask_bad    = eop_last & (|(s_eop_d & (s_eop_d + KW'(1))));
    cnt_next    = beat_cnt_q + CW'(1);
    wr_en       = 1'b0;
    wr_data     = s_data_d;
    wr_keep     = eop_last ? s_eop_d : {KW{1'b1}};
    wr_last     = eop_last;
    wr_user     = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        fire      = toks_v & s_flags_v & space & rst_n;
        s_flags_r = fire;
        wr_user   = s_flags_d;
        cnt_next  = CW'(1);
      end
      ST_IN_PKT: fire = toks_v & space & rst_n;
      ST_DROP:   consume = toks_v & rst_n;
      default:   ;
    endcase

    s_data_r = fire | consume;
    s_eop_r  = fire | consume;

    if (fire) begin
      wr_en      = 1'b1;
      beat_cnt_d = cnt_next;
      set_mask   = mask_bad;
      if (state_q == ST_IDLE) begin
        flags_d = s_flags_d;
      end
      if (eop_last) begin
        state_d = ST_IDLE;
      end else if (cnt_next == CW'(MAX_BEATS)) begin
        // Close the packet early; the remainder is swallowed in DROP
        wr_last     = 1'b1;
        wr_keep     = {KW{1'b1}};
        set_overlen = 1'b1;
        state_d     = ST_DROP;
      end else begin
        state_d = ST_IN_PKT;
      end
    end

    if (consume) begin
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
      if (eop_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Two-entry output buffer: out_* is the head presented on the bus, skid_* the second entry
  always_comb begin
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    skid_data_d = skid_data_q;
    skid_keep_d = skid_keep_q;
    skid_last_d = skid_last_q;
    skid_user_d = skid_user_q;
    rd_en       = (count_q != 2'd0) & m_axis_tready;

    unique case (count_q)
      2'd0: begin
        if (wr_en) begin
          out_data_d = wr_data;
          out_keep_d = wr_keep;
          out_last_d = wr_last;
          out_user_d = wr_user;
          count_d    = 2'd1;
        end
      end
      2'd1: begin
        if (wr_en && rd_en) begin
          out_data_d = wr_data;
          out_keep_d = wr_keep;
          out_last_d = wr_last;
          out_user_d = wr_user;
        end else if (wr_en) begin
          skid_data_d = wr_data;
          skid_keep_d = wr_keep;
          skid_last_d = wr_last;
          skid_user_d = wr_user;
          count_d     = 2'd2;
        end else if (rd_en) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (rd_en) begin
          out_data_d = skid_data_q;
          out_keep_d = skid_keep_q;
          out_last_d = skid_last_q;
          out_user_d = skid_user_q;
          count_d    = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // Sticky flags (set beats clear) and statistics
  always_comb begin
    err_mask_d    = set_mask ? 1'b1 : (clr_err ? 1'b0 : err_mask_q);
    err_overlen_d = set_overlen ? 1'b1 : (clr_err ? 1'b0 : err_overlen_q);
    pkt_cnt_d     = pkt_cnt_q;
    if (rd_en && out_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      flags_q       <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      out_keep_q    <= '0;
      out_last_q    <= 1'b0;
      out_user_q    <= '0;
      skid_data_q   <= '0;
      skid_keep_q   <= '0;
      skid_last_q   <= 1'b0;
      skid_user_q   <= '0;
      err_mask_q    <= 1'b0;
      err_overlen_q <= 1'b0;
      pkt_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      flags_q       <= flags_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_keep_q    <= out_keep_d;
      out_last_q    <= out_last_d;
      out_user_q    <= out_user_d;
      skid_data_q   <= skid_data_d;
      skid_keep_q   <= skid_keep_d;
      skid_last_q   <= skid_last_d;
      skid_user_q   <= skid_user_d;
      err_mask_q    <= err_mask_d;
      err_overlen_q <= err_overlen_d;
      pkt_cnt_q     <= pkt_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign err_mask      = err_mask_q;
  assign err_overlen   = err_overlen_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pktunit_stream_joiner.sv
// Bench for pktunit_stream_joiner: table of beats with expected output fields, scoreboard
// checked at the output handshake, plus hand sequences for stall, out-of-step and reset cases.
module tb_pktunit_stream_joiner;

  localparam int unsigned DB   = 8;
  localparam int unsigned DW   = DB * 8;
  localparam int unsigned MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data_d;
  logic          s_data_v, s_data_r;
  logic [7:0]    s_flags_d;
  logic          s_flags_v, s_flags_r;
  logic [DB-1:0] s_eop_d;
  logic          s_eop_v, s_eop_r;
  logic [DW-1:0] m_axis_tdata;
  logic [DB-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [7:0]    m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          clr_err;
  logic          err_mask, err_overlen;
  logic [31:0]   pkt_cnt;
  logic [15:0]   drop_cnt;

  pktunit_stream_joiner #(.DATA_BYTES(DB), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_d(s_data_d), .s_data_v(s_data_v), .s_data_r(s_data_r),
    .s_flags_d(s_flags_d), .s_flags_v(s_flags_v), .s_flags_r(s_flags_r),
    .s_eop_d(s_eop_d), .s_eop_v(s_eop_v), .s_eop_r(s_eop_r),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .clr_err(clr_err), .err_mask(err_mask), .err_overlen(err_overlen),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    flags;
    logic [DW-1:0] data;
    logic [DB-1:0] eop;
    bit            exp_out;
    logic [DB-1:0] exp_keep;
    bit            exp_last;
    logic [7:0]    exp_user;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    bit            last;
    logic [7:0]    user;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_cmp   = 0;
  int    n_fail  = 0;
  int    flag_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [7:0] f, input logic [DB-1:0] e, input bit o,
                              input logic [DB-1:0] k, input bit l);
    vec_t v;
    v.flags    = f;
    v.data     = {$urandom, $urandom};
    v.eop      = e;
    v.exp_out  = o;
    v.exp_keep = k;
    v.exp_last = l;
    v.exp_user = f;
    vecs.push_back(v);
  endfunction

  task automatic idle_in();
    s_data_v  = 1'b0;
    s_eop_v   = 1'b0;
    s_flags_v = 1'b0;
  endtask

  // Present one beat (flags token offered alongside) and wait for it to be taken
  task automatic drive_beat(input vec_t v);
    bit got;
    got       = 1'b0;
    s_data_d  = v.data;
    s_eop_d   = v.eop;
    s_flags_d = v.flags;
    s_data_v  = 1'b1;
    s_eop_v   = 1'b1;
    s_flags_v = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (s_data_r) begin
        got = 1'b1;
        if (v.exp_out) sb.push_back('{v.data, v.exp_keep, v.exp_last, v.exp_user});
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: beat eop=%0h flags=%0h never accepted", v.eop, v.flags);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive_beat(vecs[i]);
    idle_in();
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (sb.size() != 0 || m_axis_tvalid); c++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Output-side scoreboard and flags-token handshake counter
  always @(negedge clk) begin : mon
    beat_t e;
    if (s_flags_v && s_flags_r) flag_hs++;
    if (m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: tdata %0h tlast %0b with nothing expected", m_axis_tdata, m_axis_tlast);
      end else begin
        e = sb.pop_front();
        chk("tdata", m_axis_tdata, e.data);
        chk("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
        chk("tlast", 64'(m_axis_tlast), 64'(e.last));
        chk("tuser", 64'(m_axis_tuser), 64'(e.user));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi, e_lo, e_hi, f_lo, f_hi, g_lo, g_hi;
    bit  any_r;

    a_lo = vecs.size();
    add(8'hA5, 8'h00, 1, 8'hFF, 0);
    add(8'hA5, 8'h00, 1, 8'hFF, 0);
    add(8'hA5, 8'h0F, 1, 8'h0F, 1);
    a_hi = vecs.size() - 1;
    b_lo = vecs.size();
    add(8'h01, 8'hFF, 1, 8'hFF, 1);
    add(8'h02, 8'hFF, 1, 8'hFF, 1);
    b_hi = vecs.size() - 1;
    c_lo = vecs.size();
    add(8'h33, 8'h00, 1, 8'hFF, 0);
    add(8'h33, 8'h00, 1, 8'hFF, 0);
    add(8'h33, 8'h03, 1, 8'h03, 1);
    add(8'h44, 8'h00, 1, 8'hFF, 0);
    add(8'h44, 8'h1F, 1, 8'h1F, 1);
    c_hi = vecs.size() - 1;
    d_lo = vecs.size();
    add(8'h77, 8'h00, 1, 8'hFF, 0);
    add(8'h77, 8'h00, 1, 8'hFF, 0);
    add(8'h77, 8'h00, 1, 8'hFF, 0);
    add(8'h77, 8'h00, 1, 8'hFF, 1);
    add(8'h77, 8'h00, 0, 8'h00, 0);
    add(8'h77, 8'h00, 0, 8'h00, 0);
    add(8'h77, 8'hFF, 0, 8'h00, 0);
    add(8'h88, 8'h3F, 1, 8'h3F, 1);
    d_hi = vecs.size() - 1;
    e_lo = vecs.size();
    add(8'h99, 8'h00, 1, 8'hFF, 0);
    add(8'h99, 8'h05, 1, 8'h05, 1);
    e_hi = vecs.size() - 1;
    f_lo = vecs.size();
    add(8'hC3, 8'h00, 1, 8'hFF, 0);
    add(8'hC3, 8'h00, 1, 8'hFF, 0);
    f_hi = vecs.size() - 1;
    g_lo = vecs.size();
    add(8'h3C, 8'h00, 1, 8'hFF, 0);
    add(8'h3C, 8'h7F, 1, 8'h7F, 1);
    g_hi = vecs.size() - 1;

    // Reset with all tokens offered: nothing may be accepted
    rst_n         = 1'b0;
    m_axis_tready = 1'b1;
    clr_err       = 1'b0;
    s_data_d      = '1;
    s_eop_d       = '1;
    s_flags_d     = 8'hEE;
    s_data_v      = 1'b1;
    s_eop_v       = 1'b1;
    s_flags_v     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_r", 64'(s_data_r), 64'd0);
    chk("rst_flags_r", 64'(s_flags_r), 64'd0);
    chk("rst_eop_r", 64'(s_eop_r), 64'd0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_err_mask", 64'(err_mask), 64'd0);
    chk("rst_err_overlen", 64'(err_overlen), 64'd0);
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three-beat packet
    run_vecs(a_lo, a_hi);
    drain();
    chk("a_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("a_flag_hs", 64'(flag_hs), 64'd1);

    // Back-to-back single-beat packets
    run_vecs(b_lo, b_hi);
    drain();
    chk("b_pkt_cnt", 64'(pkt_cnt), 64'd3);
    chk("b_flag_hs", 64'(flag_hs), 64'd3);

    // Downstream stall: exactly two beats buffered, head held stable
    m_axis_tready = 1'b0;
    fork
      run_vecs(c_lo, c_hi);
      begin
        logic [DW-1:0] held;
        repeat (3) @(negedge clk);
        held = m_axis_tdata;
        repeat (7) @(negedge clk);
        chk("stall_buffered", 64'(sb.size()), 64'd2);
        chk("stall_data_r", 64'(s_data_r), 64'd0);
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_hold", m_axis_tdata, held);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
      end
    join
    drain();
    chk("c_pkt_cnt", 64'(pkt_cnt), 64'd5);

    // Over-length packet truncated at MAX_BEATS, remainder dropped, next packet clean
    run_vecs(d_lo, d_hi);
    drain();
    chk("d_err_overlen", 64'(err_overlen), 64'd1);
    chk("d_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("d_pkt_cnt", 64'(pkt_cnt), 64'd7);
    chk("d_flag_hs", 64'(flag_hs), 64'd7);
    chk("d_err_mask", 64'(err_mask), 64'd0);

    // Non-contiguous eop mask forwarded as-is and flagged
    run_vecs(e_lo, e_hi);
    drain();
    chk("e_err_mask", 64'(err_mask), 64'd1);
    chk("e_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // Out-of-step tokens are never partially consumed
    any_r     = 1'b0;
    s_data_d  = {$urandom, $urandom};
    s_flags_d = 8'h5E;
    s_eop_d   = 8'hFF;
    s_data_v  = 1'b1;
    s_flags_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      any_r |= s_data_r | s_flags_r | s_eop_r;
    end
    chk("oos_no_eop_ready", 64'(any_r), 64'd0);
    @(posedge clk);
    #1;
    s_data_v  = 1'b0;
    s_flags_v = 1'b0;
    s_eop_v   = 1'b1;
    @(negedge clk);
    chk("oos_eop_only", 64'(s_eop_r), 64'd0);
    @(posedge clk);
    #1;
    idle_in();

    // Sticky flag clear
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("clr_err_mask", 64'(err_mask), 64'd0);
    chk("clr_err_overlen", 64'(err_overlen), 64'd0);
    chk("clr_keeps_drop_cnt", 64'(drop_cnt), 64'd3);

    // Reset mid-packet: buffered beats discarded, next packet carries its own flags
    m_axis_tready = 1'b0;
    run_vecs(f_lo, f_hi);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    run_vecs(g_lo, g_hi);
    drain();
    chk("g_pkt_cnt", 64'(pkt_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
